// File: rtl/mux_pkg.sv
// Shared mux helpers: arbiter state encoding, select-width helper and the
// round-robin search used by rr_pick.
package mux_pkg;

    localparam int MAX_N = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic int mux_sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // First set bit of mask found by searching base+1, base+2, ... modulo n;
    // base itself is the last candidate. Returns base when mask is empty.
    function automatic logic [IDX_W-1:0] rr_next_idx(input logic [IDX_W-1:0] base,
                                                     input logic [MAX_N-1:0] mask,
                                                     input int n);
        logic [IDX_W:0] idx;
        rr_next_idx = base;
        for (int k = MAX_N; k >= 1; k--) begin
            if (k <= n) begin
                idx = (IDX_W+1)'(base) + (IDX_W+1)'(k);
                if (idx >= (IDX_W+1)'(n))
                    idx = idx - (IDX_W+1)'(n);
                if (mask[idx[IDX_W-1:0]])
                    rr_next_idx = idx[IDX_W-1:0];
            end
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: index of the first requester after base (modulo N) and
// a flag saying whether any requester was set at all.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] base,
    output logic [SW-1:0] idx,
    output logic          found
);

    logic [MAX_N-1:0] mask_ext;

    always_comb begin
        mask_ext        = '0;
        mask_ext[N-1:0] = mask;
    end

    assign idx   = SW'(rr_next_idx(IDX_W'(base), mask_ext, N));
    assign found = |mask;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 data mux onto one
// valid/ready consumer port.
//   state    | meaning
//   ST_IDLE  | no grant held; arbitrate on any req
//   ST_GRANT | sel holds the granted requester until its transfer or withdrawal
module rr_mux_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   ack,
    output logic [SW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ready,
    output logic           busy
);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          req_sel;
    logic          xfer;
    logic [N-1:0]  others;
    logic [N-1:0]  pick_mask;
    logic [SW-1:0] pick_base;
    logic [SW-1:0] pick_idx;
    logic          pick_found;

    always_comb begin
        req_sel  = 1'b0;
        out_data = '0;
        others   = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_q == SW'(i)) begin
                req_sel  = req[i];
                out_data = in_data[i*W +: W];
            end else begin
                others[i] = req[i];
            end
        end
    end

    assign busy      = (state_q == ST_GRANT);
    assign sel       = sel_q;
    assign out_valid = busy & req_sel;
    assign xfer      = out_valid & out_ready;

    always_comb begin
        ack = '0;
        for (int i = 0; i < N; i++)
            ack[i] = xfer & (sel_q == SW'(i));
    end

    // While granted, the next search excludes the word being served so a
    // sole requester takes a bubble instead of winning twice in a row.
    assign pick_mask = busy ? others : req;
    assign pick_base = busy ? sel_q  : ptr_q;

    rr_pick #(.N(N), .SW(SW)) u_pick (
        .mask  (pick_mask),
        .base  (pick_base),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    ptr_d = sel_q;
                    if (pick_found)
                        sel_d = pick_idx;
                    else
                        state_d = ST_IDLE;
                end else if (!req_sel) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ptr_q   <= SW'(N-1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule
